axi4_slave_mem: RTL
===================

Name: axi4_slave_mem

Overview:
Synthesizable AXI4 memory slave. It is the responder end of the AXI4 master bus-functional model used in block testbenches. It holds a word-addressed register array and services one write burst and one read burst at a time; the write and read channels run independently. It is instantiated in benches and as a scratch-pad target on the interconnect.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of the AWID/BID/ARID/RID fields
MEM_WORDS_LOG2, 10, log2 of the memory depth in 32-bit words (default 4 KiB)
WAIT_SEED, 16'hACE1, initial LFSR value, used only when the optional feature is enabled

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESETN  in  1  synchronous, active-low reset
S_AXI_AWID  in  C_S_AXI_ID_WIDTH  write ID
S_AXI_AWADDR  in  32  byte address
S_AXI_AWLEN  in  8  number of beats minus 1
S_AXI_AWSIZE  in  3  beat size code
S_AXI_AWBURST  in  2  burst type: 0=FIXED, 1=INCR, 2=WRAP
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  per-byte write enables
S_AXI_WLAST  in  1  last beat marker
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BID  out  C_S_AXI_ID_WIDTH  response ID
S_AXI_BRESP  out  2  write response: OKAY=0, SLVERR=2
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  ID/32/8/3/2  read address fields, same meaning as the AW fields
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RID  out  C_S_AXI_ID_WIDTH  read ID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last beat marker
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake

Behaviour:
- Reset (ARESETN=0 at a rising edge):
  - All outputs go to 0, except AWREADY=1 and ARREADY=1.
  - Both FSMs return to IDLE; any in-flight burst is abandoned with no response.
  - Memory contents are not cleared.
- All outputs are registered. A handshake completes on a rising edge where VALID&READY=1.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On the AW handshake, latch id, word address = AWADDR[MEM_WORDS_LOG2+1:2], len, burst, and err = (AWSIZE!=2) | (AWBURST==2). Next cycle: AWREADY=0, WREADY=1.
  - W_DATA: each W handshake writes the bytes enabled by WSTRB into mem[addr], unless err is set.
  - Address update per beat: INCR adds 1 word; FIXED holds. The address wraps modulo 2^MEM_WORDS_LOG2.
  - The beat counter ends the burst after len+1 beats. If WLAST disagrees with (beat==len) on any beat, err is set; the data of the mismatched beat is still written.
  - After the final beat: WREADY=0, BVALID=1, BID=latched id, BRESP = err ? 2 : 0.
  - W_RESP: hold BVALID until BREADY. On the B handshake: BVALID=0 and AWREADY=1 on the next cycle.
  - Minimum write turnaround is AW, then one cycle per beat, then B.
  - W data presented before AW is simply not accepted (WREADY=0 in W_IDLE).
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the AR handshake, latch the fields with the same err rule. Next cycle: ARREADY=0, RVALID=1, RDATA=mem[addr], RLAST=(len==0), RRESP = err ? 2 : 0.
  - An errored burst returns RDATA=32'h0 for every beat.
  - R_DATA: on each R handshake, the next beat's RDATA/RLAST are registered on the same edge, so back-to-back beats are possible. With RREADY=0 all R outputs hold stable.
  - After the beat with RLAST: RVALID=0, ARREADY=1.
- Simultaneous write and read to the same word on the same edge: the read returns the old data.
- The write and read FSMs never stall each other.

Optional Feature:
AXI4_SLAVE_MEM_WAIT_EN:
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seeded with WAIT_SEED on reset) advances every cycle. When its bit 0 = 1, that cycle suppresses AWREADY, WREADY and ARREADY assertion, and suppresses presentation of a new R beat.
- Once RVALID is asserted, it is never withdrawn before its handshake, to stay AXI-legal.
- When undefined: no LFSR is built, and the timing is exactly as described under Behaviour.

Test Plan:
- Single write: AWADDR=0x10, AWLEN=0, WDATA=0x12345678, WSTRB=4'hF -> BRESP=0, BID echoed; a read of 0x10 returns 0x12345678 with RLAST=1.
- INCR burst: write AWLEN=3 at 0x100 with data 0xA0..0xA3; read ARLEN=3 with RREADY toggling 1,0,1,1,0,1 -> beats 0xA0..0xA3 in order, RLAST only on beat 4, and RDATA stable while stalled.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with WSTRB=4'b0101 -> reads back 0xFF00FF00.
- Errors:
  - AWSIZE=1 -> BRESP=2 and memory unchanged.
  - ARBURST=2 -> RRESP=2 on every beat with RDATA=0.
  - WLAST asserted on beat 1 of AWLEN=2 -> BRESP=2.
- Concurrency/wrap: a write burst to the top word with AWLEN=1 wraps to word 0; a concurrent read of word 0 on the same edge returns the old value.
- Reset mid-burst: drop ARESETN during W_DATA -> next cycle AWREADY=1, BVALID=0, and no B is ever issued for the aborted burst.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 memory slave with independent write and read burst engines
// Ports: ACLK/ARESETN (sync, active-low); AW/W/B write channels; AR/R read channels.
// All outputs are registered; the memory is a 2^MEM_WORDS_LOG2 x 32-bit word array.
// Optional: define AXI4_SLAVE_MEM_WAIT_EN to add LFSR-driven random wait states.
module axi4_slave_mem #(
  parameter int          C_S_AXI_ID_WIDTH = 1,
  parameter int          MEM_WORDS_LOG2   = 10,
  parameter logic [15:0] WAIT_SEED        = 16'hACE1
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_AWID,
  input  logic [31:0]                 S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [31:0]                 S_AXI_WDATA,
  input  logic [3:0]                  S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_ARID,
  input  logic [31:0]                 S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_RID,
  output logic [31:0]                 S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);
  localparam int AB = MEM_WORDS_LOG2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  logic [31:0] mem [0:(1<<AB)-1];
  logic stall;
  logic unused_ok;
  logic [1:0] w_st_q, w_st_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, werr_q, werr_d;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [1:0] bresp_q, bresp_d, wburst_q, wburst_d;
  logic [AB-1:0] waddr_q, waddr_d;
  logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [0:0] r_st_q, r_st_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d, rburst_q, rburst_d;
  logic [AB-1:0] raddr_q, raddr_d;
  logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, load;
  logic [AB-1:0] src_addr;
  logic [7:0] src_beat, src_len;
  logic [1:0] src_burst;
  logic src_err;
  assign unused_ok = ^{S_AXI_AWADDR[31:AB+2], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[31:AB+2], S_AXI_ARADDR[1:0], WAIT_SEED};
`ifdef AXI4_SLAVE_MEM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // Ready/valid outputs are registered, so the stall decision uses the value the LFSR will hold next cycle
  assign stall = lfsr_d[0];
  always_ff @(posedge ACLK) lfsr_q <= !ARESETN ? WAIT_SEED : lfsr_d;
`else
  assign stall = 1'b0;
`endif
  function automatic logic [AB-1:0] nxt(input logic [AB-1:0] a, input logic [1:0] b);
    return a + AB'(b == 2'd1);
  endfunction
  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign b_hs  = S_AXI_BREADY & bvalid_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;
  assign r_hs  = S_AXI_RREADY & rvalid_q;
  always_comb begin
    w_st_d = w_st_q;
    awready_d = awready_q;
    wready_d = wready_q;
    bvalid_d = bvalid_q;
    bid_d = bid_q;
    bresp_d = bresp_q;
    waddr_d = waddr_q;
    wlen_d = wlen_q;
    wbeat_d = wbeat_q;
    wburst_d = wburst_q;
    werr_d = werr_q;
    if (w_st_q == W_IDLE) begin
      awready_d = ~stall;
      if (aw_hs) begin
        bid_d = S_AXI_AWID;
        waddr_d = S_AXI_AWADDR[AB+1:2];
        wlen_d = S_AXI_AWLEN;
        wburst_d = S_AXI_AWBURST;
        werr_d = (S_AXI_AWSIZE != 3'd2) | (S_AXI_AWBURST == 2'd2);
        wbeat_d = 8'd0;
        awready_d = 1'b0;
        wready_d = ~stall;
        w_st_d = W_DATA;
      end
    end else if (w_st_q == W_DATA) begin
      wready_d = ~stall;
      if (w_hs) begin
        waddr_d = nxt(waddr_q, wburst_q);
        wbeat_d = wbeat_q + 8'd1;
        werr_d = werr_q | (S_AXI_WLAST != (wbeat_q == wlen_q));
        if (wbeat_q == wlen_q) begin
          w_st_d = W_RESP;
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d = werr_d ? 2'b10 : 2'b00;
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
      awready_d = ~stall;
      w_st_d = W_IDLE;
    end
  end
  // A beat is sourced from the AR channel directly when idle, otherwise from the latched burst state
  always_comb begin
    r_st_d = r_st_q;
    arready_d = arready_q;
    rvalid_d = rvalid_q;
    rlast_d = rlast_q;
    rerr_d = rerr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rburst_d = rburst_q;
    raddr_d = raddr_q;
    rlen_d = rlen_q;
    rbeat_d = rbeat_q;
    rid_d = rid_q;
    src_addr = (r_st_q == R_IDLE) ? S_AXI_ARADDR[AB+1:2] : raddr_q;
    src_beat = (r_st_q == R_IDLE) ? 8'd0 : rbeat_q;
    src_len = (r_st_q == R_IDLE) ? S_AXI_ARLEN : rlen_q;
    src_burst = (r_st_q == R_IDLE) ? S_AXI_ARBURST : rburst_q;
    src_err = (r_st_q == R_IDLE) ? ((S_AXI_ARSIZE != 3'd2) | (S_AXI_ARBURST == 2'd2)) : rerr_q;
    load = ((r_st_q == R_IDLE) ? ar_hs : (~rvalid_q | (r_hs & ~rlast_q))) & ~stall;
    if (r_st_q == R_IDLE) begin
      arready_d = ~stall;
      if (ar_hs) begin
        arready_d = 1'b0;
        rid_d = S_AXI_ARID;
        rlen_d = S_AXI_ARLEN;
        rburst_d = S_AXI_ARBURST;
        rerr_d = src_err;
        raddr_d = src_addr;
        rbeat_d = 8'd0;
        r_st_d = R_DATA;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
      if (rlast_q) begin
        r_st_d = R_IDLE;
        arready_d = ~stall;
      end
    end
    if (load) begin
      rvalid_d = 1'b1;
      rdata_d = src_err ? 32'h0 : mem[src_addr];
      rlast_d = src_beat == src_len;
      rresp_d = src_err ? 2'b10 : 2'b00;
      raddr_d = nxt(src_addr, src_burst);
      rbeat_d = src_beat + 8'd1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_st_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q <= '0;
      bresp_q <= 2'b00;
      waddr_q <= '0;
      wlen_q <= 8'd0;
      wbeat_q <= 8'd0;
      wburst_q <= 2'b00;
      werr_q <= 1'b0;
      r_st_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rerr_q <= 1'b0;
      rdata_q <= 32'h0;
      rresp_q <= 2'b00;
      rburst_q <= 2'b00;
      raddr_q <= '0;
      rlen_q <= 8'd0;
      rbeat_q <= 8'd0;
      rid_q <= '0;
    end else begin
      w_st_q <= w_st_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bid_q <= bid_d;
      bresp_q <= bresp_d;
      waddr_q <= waddr_d;
      wlen_q <= wlen_d;
      wbeat_q <= wbeat_d;
      wburst_q <= wburst_d;
      werr_q <= werr_d;
      r_st_q <= r_st_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rerr_q <= rerr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rburst_q <= rburst_d;
      raddr_q <= raddr_d;
      rlen_q <= rlen_d;
      rbeat_q <= rbeat_d;
      rid_q <= rid_d;
    end
  end
  // A beat that itself flags the WLAST mismatch is still stored; only later beats are dropped
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_hs && !werr_q)
      for (int i = 0; i < 4; i++)
        if (S_AXI_WSTRB[i]) mem[waddr_q][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
  end
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = wready_q;
  assign S_AXI_BID = bid_q;
  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID = rid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RLAST = rlast_q;
  assign S_AXI_RVALID = rvalid_q;
endmodule
